// File: rtl/midi_tx_if.sv
// rtl/midi_tx_if.sv - byte handshake between a MIDI byte source and midi_tx
interface midi_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/midi_tx.sv
// rtl/midi_tx.sv - MIDI UART transmitter with byte FIFO; optional MIDI_TX_RUNNING_STATUS_EN
// suppresses a channel status byte that repeats the last one sent.
module midi_tx #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 31250,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        fpga_clk,
    input  logic                        reset_n,
    midi_tx_if.slave                    s,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          txd_q, txd_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          push;
    logic          pop;
    logic          drop;
    logic [7:0]    head;

    assign head       = mem_q[rd_ptr_q];
    assign s.tx_ready = (level_q < LEVEL_FULL);
    assign push       = s.tx_valid && s.tx_ready;

`ifdef MIDI_TX_RUNNING_STATUS_EN
    // 0x00 never matches a channel status byte, so it doubles as "no status held".
    logic [7:0] last_q, last_d;
    logic       head_is_chan;

    assign head_is_chan = head[7] && (head[7:4] != 4'hF);
    assign drop         = head_is_chan && (head == last_q);

    always_comb begin
        last_d = last_q;
        if (pop && !drop) begin
            if (head_is_chan) begin
                last_d = head;
            end else if (head[7:3] == 5'b11110) begin
                last_d = 8'h00;
            end
        end
    end
`else
    assign drop = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop = 1'b1;
                    if (!drop) begin
                        state_d = START;
                        shreg_d = head;
                        cnt_d   = '0;
                    end
                end
            end
            START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    // Chain straight into the next frame; a dropped byte costs one IDLE cycle.
                    if (level_q != '0) begin
                        pop = 1'b1;
                        if (drop) begin
                            state_d = IDLE;
                        end else begin
                            state_d = START;
                            shreg_d = head;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line follows the registered state, so it lags the FSM by one cycle.
        unique case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shreg_q[0];
            default: txd_d = 1'b1;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge fpga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            txd_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
            last_q   <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            txd_q    <= txd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
`ifdef MIDI_TX_RUNNING_STATUS_EN
            last_q   <= last_d;
`endif
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s.tx_data;
        end
    end

    assign txd        = txd_q;
    assign busy       = (state_q != IDLE) || (level_q != '0);
    assign fifo_level = level_q;
endmodule

// File: tb/tb_midi_tx.sv
// tb/tb_midi_tx.sv - directed bench for midi_tx; bit period scaled to 16 clocks to keep runs short
module tb_midi_tx;
    localparam int CLK_HZ = 500000;
    localparam int BAUD   = 31250;
    localparam int DIV    = 16;
    localparam int FRAME  = 10 * DIV;
    localparam int DEPTH  = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       txd;
    logic       busy;
    logic [4:0] fifo_level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    midi_tx_if bus();

    midi_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .fpga_clk  (clk),
        .reset_n   (rst_n),
        .s         (bus),
        .txd       (txd),
        .busy      (busy),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line receiver: mid-bit sampling relative to the first low cycle.
    logic [7:0] rx_q[$];
    int         rx_stop_bad = 0;
    bit         in_frame = 1'b0;
    int         mon_start = 0;
    logic [7:0] mon_sh = 8'h00;

    always @(negedge clk) begin : mon
        int k;
        if (!rst_n) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (txd === 1'b0) begin
                in_frame  = 1'b1;
                mon_start = cyc;
            end
        end else begin
            k = cyc - mon_start;
            if (k >= DIV + DIV/2 && k < 9*DIV && ((k - DIV/2) % DIV) == 0)
                mon_sh[(k - DIV/2)/DIV - 1] = txd;
            if (k == 9*DIV + DIV/2) begin
                if (txd !== 1'b1) rx_stop_bad++;
                rx_q.push_back(mon_sh);
                in_frame = 1'b0;
            end
        end
    end

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j >= 1 && j <= 8) return b[j-1];
        return 1'b1;
    endfunction

    task automatic push_byte(input logic [7:0] b, output int n);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(posedge clk); #1;
        n = cyc;
        bus.tx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        rx_q.delete();
        rx_stop_bad = 0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", txd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.tx_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (txd !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL reset_release: got txd=%b busy=%b want 1/0", txd, busy); end
    endtask

    task automatic test_single_byte();
        int n;
        int errs;
        int first_bad;
        logic exp;
        logic [7:0] b;
        b = 8'h90;
        errs = 0;
        first_bad = 0;
        do_reset();
        push_byte(b, n);
        total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL single_level_push: got %0d want 1", fifo_level); end
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL single_level_pop: got %0d want 0", fifo_level); end
            end
            exp = (k < 2) ? 1'b1 : frame_bit(b, (k - 2) / DIV);
            if (txd !== exp) begin
                if (errs == 0) first_bad = k;
                errs++;
            end
            if (k == FRAME) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_high: got %b want 1", busy); end
            end
            if (k == FRAME + 1) begin
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_low: got %b want 0", busy); end
            end
        end
        total++; if (errs != 0) begin bad++; $display("FAIL single_wave: %0d wrong cycles, first at N+%0d, want 0", errs, first_bad); end
        total++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h90 || rx_stop_bad != 0) begin
            bad++; $display("FAIL single_rx: got %0d bytes first=%h stopbad=%0d want 1 byte 90", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, rx_stop_bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int n;
        int n2;
        int peak;
        int errs;
        int first_bad;
        int idx;
        logic exp;
        bytes = '{8'h90, 8'h3C, 8'h64};
        errs = 0;
        first_bad = 0;
        peak = 0;
        do_reset();
        push_byte(bytes[0], n);
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        push_byte(bytes[1], n2);
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        push_byte(bytes[2], n2);
        for (int k = 2; k <= 3*FRAME + 1; k++) begin
            if (k > 2) begin
                @(posedge clk); #1;
            end
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            idx = k - 2;
            exp = (idx < 3*FRAME) ? frame_bit(bytes[idx / FRAME], (idx % FRAME) / DIV) : 1'b1;
            if (txd !== exp) begin
                if (errs == 0) first_bad = k;
                errs++;
            end
            if (k == 3*FRAME) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_high: got %b want 1", busy); end
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_low: got %b want 0", busy); end
        total++; if (peak != 2) begin bad++; $display("FAIL b2b_peak_level: got %0d want 2", peak); end
        total++; if (errs != 0) begin bad++; $display("FAIL b2b_wave: %0d wrong cycles, first at N+%0d, want 0", errs, first_bad); end
        total++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'h90 || rx_q[1] !== 8'h3C || rx_q[2] !== 8'h64) begin
            bad++; $display("FAIL b2b_rx: got %0d bytes want 90 3C 64", rx_q.size());
        end
    endtask

    task automatic test_fill();
        int accepted;
        int edges;
        int ready_errs;
        bit was_ready;
        bit ok;
        int order_errs;
        accepted = 0;
        edges = 0;
        ready_errs = 0;
        order_errs = 0;
        do_reset();
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'd1;
        while (accepted < 17 && edges < 100) begin
            was_ready = bus.tx_ready;
            @(posedge clk); #1;
            edges++;
            if (was_ready) begin
                accepted++;
                bus.tx_data = 8'((accepted * 7) + 1);
            end
        end
        total++; if (edges != 17) begin bad++; $display("FAIL fill_edges: got %0d want 17", edges); end
        total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_low: got %b want 0", bus.tx_ready); end
        total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL fill_level_full: got %0d want 16", fifo_level); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.tx_ready !== 1'b0 || fifo_level !== 5'd16) ready_errs++;
        end
        bus.tx_valid = 1'b0;
        total++; if (ready_errs != 0) begin bad++; $display("FAIL fill_hold_full: got %0d bad cycles want 0", ready_errs); end
        wait_idle(17*FRAME + 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL fill_idle_timeout: got busy=%b want 0", busy); end
        total++; if (rx_q.size() != 17) begin bad++; $display("FAIL fill_rx_count: got %0d want 17", rx_q.size()); end
        for (int i = 0; i < 17 && i < rx_q.size(); i++)
            if (rx_q[i] !== 8'((i * 7) + 1)) order_errs++;
        total++; if (order_errs != 0 || rx_stop_bad != 0) begin bad++; $display("FAIL fill_rx_order: got %0d wrong bytes %0d bad stops want 0", order_errs, rx_stop_bad); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int n2;
        int hi_errs;
        hi_errs = 0;
        do_reset();
        push_byte(8'h90, n);
        push_byte(8'h3C, n2);
        repeat ((n + 2 + 4*DIV + DIV/2) - n2) @(posedge clk);
        #1;
        total++; if (txd !== 1'b0) begin bad++; $display("FAIL midrst_bit3_before: got %b want 0", txd); end
        rst_n = 1'b0;
        #1;
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL midrst_txd: got %b want 1", txd); end
        total++; if (busy !== 1'b0 || fifo_level !== 5'd0 || bus.tx_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_state: got busy=%b level=%0d ready=%b want 0/0/1", busy, fifo_level, bus.tx_ready);
        end
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3*FRAME; i++) begin
            @(posedge clk); #1;
            if (txd !== 1'b1 || busy !== 1'b0) hi_errs++;
        end
        total++; if (hi_errs != 0) begin bad++; $display("FAIL midrst_quiet: got %0d active cycles want 0", hi_errs); end
        total++; if (rx_q.size() != 0) begin bad++; $display("FAIL midrst_rx: got %0d frames want 0", rx_q.size()); end
    endtask

`ifdef MIDI_TX_RUNNING_STATUS_EN
    task automatic test_running_status();
        logic [7:0] seqs [3][6];
        logic [7:0] exps [3][6];
        int         seq_len [3];
        int         exp_len [3];
        int         n;
        bit         ok;
        int         errs;
        seqs    = '{'{8'h90, 8'h3C, 8'h64, 8'h90, 8'h40, 8'h00},
                    '{8'h90, 8'hF8, 8'h90, 8'h00, 8'h00, 8'h00},
                    '{8'h90, 8'hF0, 8'h90, 8'h00, 8'h00, 8'h00}};
        exps    = '{'{8'h90, 8'h3C, 8'h64, 8'h40, 8'h00, 8'h00},
                    '{8'h90, 8'hF8, 8'h00, 8'h00, 8'h00, 8'h00},
                    '{8'h90, 8'hF0, 8'h90, 8'h00, 8'h00, 8'h00}};
        seq_len = '{6, 3, 3};
        exp_len = '{5, 2, 3};
        for (int sc = 0; sc < 3; sc++) begin
            do_reset();
            for (int i = 0; i < seq_len[sc]; i++) push_byte(seqs[sc][i], n);
            wait_idle(7*FRAME, ok);
            total++; if (!ok) begin bad++; $display("FAIL rs%0d_idle_timeout: got busy=%b want 0", sc, busy); end
            errs = 0;
            for (int i = 0; i < exp_len[sc] && i < rx_q.size(); i++)
                if (rx_q[i] !== exps[sc][i]) errs++;
            total++;
            if (rx_q.size() != exp_len[sc] || errs != 0) begin
                bad++; $display("FAIL rs%0d_frames: got %0d frames %0d wrong want %0d frames", sc, rx_q.size(), errs, exp_len[sc]);
            end
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want test end");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_fill();
        test_reset_mid_frame();
`ifdef MIDI_TX_RUNNING_STATUS_EN
        test_running_status();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/midi_tx.md
MIDI_TX -- requirements
Module: midi_tx

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 50000000, meaning the fpga_clk frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 31250, meaning the MIDI bit rate.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 16, meaning byte FIFO entries; power of two, 2..256.
REQ-004 SHALL have port fpga_clk  input  1  system clock; the only clock.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port tx_data  input  8  byte to send.
REQ-007 SHALL have port tx_valid  input  1  tx_data valid.
REQ-008 SHALL have port tx_ready  output  1  FIFO can accept a byte.
REQ-009 SHALL have port txd  output  1  non-inverted UART line, idle high; the top level inverts it for the opto/driver.
REQ-010 SHALL have port busy  output  1  FIFO non-empty or frame in progress.
REQ-011 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted.

Function
REQ-012 SHALL accept a byte on any rising edge where tx_valid=1 and tx_ready=1; tx_data SHALL be ignored otherwise.
REQ-013 SHALL drive tx_ready = (fifo_level < FIFO_DEPTH), combinationally from registered state.
REQ-014 SHALL set bit period to DIV = CLK_HZ/BAUD clocks (integer division); DIV is 1600 at the defaults.
REQ-015 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-016 SHALL go IDLE->START when the FIFO is non-empty, popping the head byte into the shift register.
REQ-017 SHALL go START->DATA after DIV cycles; DATA SHALL last 8*DIV cycles, sending LSB first.
REQ-018 SHALL go DATA->STOP; STOP SHALL drive txd=1 for DIV cycles.
REQ-019 SHALL, at the end of STOP, go directly to START if the FIFO is non-empty, with no idle gap; otherwise it SHALL go to IDLE.
REQ-020 SHALL, for a byte accepted on edge N into an empty FIFO with the FSM in IDLE, drive txd low from edge N+2.
REQ-021 SHALL, when a push and a pop occur on the same edge (including when the FIFO is full), perform both and leave fifo_level unchanged.
REQ-022 SHALL keep txd registered and glitch-free; txd=0 only in START and in DATA bits equal to 0.
REQ-023 SHALL clear busy only when the FSM is in IDLE and the FIFO is empty.
REQ-024 SHALL wrap the FIFO pointers modulo FIFO_DEPTH.

Reset
REQ-025 SHALL, on reset_n=0, immediately (without a clock) force txd=1, busy=0, fifo_level=0, tx_ready=1, FSM=IDLE, and clear the running-status register.
REQ-026 SHALL abort any frame in progress on reset and discard queued bytes; the truncated frame SHALL NOT be resumed after reset.
REQ-027 SHALL resume normal operation on the first rising edge after reset_n deasserts.

Configuration
REQ-028 SHALL support macro MIDI_TX_RUNNING_STATUS_EN.
REQ-029 With MIDI_TX_RUNNING_STATUS_EN defined: a popped byte in 0x80-0xEF equal to the last transmitted status SHALL be dropped without a frame; the drop SHALL cost 1 cycle.
REQ-030 With MIDI_TX_RUNNING_STATUS_EN defined: a transmitted byte in 0x80-0xEF SHALL update the last-status register; bytes 0xF0-0xF7 SHALL clear it; bytes 0xF8-0xFF and data bytes SHALL leave it unchanged.
REQ-031 Without MIDI_TX_RUNNING_STATUS_EN: every accepted byte SHALL be transmitted, and the last-status logic SHALL be absent.

Verification
REQ-032 SHALL cover: push 0x90 at idle -> txd low at N+2 for 1600 cycles, bits 0,0,0,0,1,0,0,1, stop high; busy drops after 16000 cycles.
REQ-033 SHALL cover: push 0x90,0x3C,0x64 back-to-back -> 30 contiguous bit periods with no idle gap; fifo_level peaks at 2.
REQ-034 SHALL cover: 17 pushes with tx_valid held high (depth 16) -> tx_ready low once full, every accepted byte sent in order, none lost.
REQ-035 SHALL cover: with the macro, push 0x90,0x3C,0x64,0x90,0x40,0x00 -> 5 frames; second 0x90 suppressed.
REQ-036 SHALL cover: with the macro, push 0x90,0xF8,0x90 -> 0xF8 sent, second 0x90 suppressed; push 0x90,0xF0,0x90 -> both 0x90 sent.
REQ-037 SHALL cover: assert reset_n=0 in the middle of DATA bit 3 -> txd=1 the same cycle; after release, txd stays high with no frames while nothing is pushed.
